// File: rtl/cvxif_mac_pkg.sv
// Shared types and constants for the CV-X-IF int8 dot-product / MAC coprocessor.
package cvxif_mac_pkg;

    localparam int unsigned CVXIF_XLEN     = 32;
    localparam int unsigned CVXIF_ID_WIDTH = 2;
    localparam logic [6:0]  OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        DOTP4 = 3'd0,
        MAC   = 3'd1,
        ACCRD = 3'd2,
        ACCWR = 3'd3
    } mac_op_e;

    typedef struct packed {
        logic [CVXIF_ID_WIDTH-1:0] id;
        logic [4:0]                rd;
        mac_op_e                   op;
        logic [CVXIF_XLEN-1:0]     rs1;
        logic [CVXIF_XLEN-1:0]     rs2;
    } pend_entry_t;

    typedef struct packed {
        logic [CVXIF_ID_WIDTH-1:0] id;
        logic [4:0]                rd;
        logic [CVXIF_XLEN-1:0]     data;
    } result_t;

    // funct3 values 4..7 are unused; bit 2 set means not ours.
    function automatic logic is_mac_instr(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        return (opcode == OPCODE_CUSTOM0) && (funct7 == 7'd0) && !funct3[2];
    endfunction

endpackage

// File: rtl/cvxif_mac_coproc_if.sv
// CV-X-IF issue/commit/result signal bundle; master = core, slave = coprocessor.
interface cvxif_mac_coproc_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ID_WIDTH = 2
);
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [31:0]           issue_instr_i;
    logic [ID_WIDTH-1:0]   issue_id_i;
    logic [2*XLEN-1:0]     issue_rs_i;
    logic [1:0]            issue_rs_valid_i;
    logic                  issue_accept_o;
    logic                  issue_writeback_o;
    logic                  commit_valid_i;
    logic [ID_WIDTH-1:0]   commit_id_i;
    logic                  commit_kill_i;
    logic                  result_valid_o;
    logic                  result_ready_i;
    logic [ID_WIDTH-1:0]   result_id_o;
    logic [XLEN-1:0]       result_data_o;
    logic [4:0]            result_rd_o;
    logic                  result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
    );
endinterface

// File: rtl/cvxif_mac_dotp4.sv
// Combinational signed int8x4 dot product; 16-bit lane products, 32-bit sign-extended sum.
module cvxif_mac_dotp4 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [15:0] ea, eb, prod;

    always_comb begin
        y    = '0;
        ea   = '0;
        eb   = '0;
        prod = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            ea   = {{8{a[8*i+7]}}, a[8*i +: 8]};
            eb   = {{8{b[8*i+7]}}, b[8*i +: 8]};
            prod = ea * eb;
            y    = y + {{16{prod[15]}}, prod};
        end
    end
endmodule

// File: rtl/cvxif_mac_coproc.sv
// CV-X-IF responder: int8x4 dot product and 32-bit accumulator, executed at commit.
// Define CVXIF_MAC_SATURATE_EN to make the MAC add saturate instead of wrap.
module cvxif_mac_coproc
    import cvxif_mac_pkg::*;
#(
    parameter int unsigned XLEN       = CVXIF_XLEN,
    parameter int unsigned ID_WIDTH   = CVXIF_ID_WIDTH,
    parameter int unsigned PEND_DEPTH = 2
) (
    input logic               clk_i,
    input logic               rst_ni,
    cvxif_mac_coproc_if.slave cvxif
);
    localparam int unsigned PTR_W = $clog2(PEND_DEPTH);
    localparam int unsigned CNT_W = $clog2(PEND_DEPTH + 1);

    pend_entry_t         fifo_q [PEND_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [XLEN-1:0]     acc_q, acc_d;
    logic                res_valid_q;
    result_t             res_q;

    logic [6:0]          opcode, funct7;
    logic [2:0]          funct3;
    logic                unused_instr;
    logic                dec_ok, accept, full, empty, push, pop;
    logic                head_match, needs_wb, res_free, exec, load_res;
    logic [ID_WIDTH-1:0] head_id;
    pend_entry_t         head, new_entry;
    logic [XLEN-1:0]     dotp, mac_wrap, mac_sum, res_data;

    assign opcode       = cvxif.issue_instr_i[6:0];
    assign funct3       = cvxif.issue_instr_i[14:12];
    assign funct7       = cvxif.issue_instr_i[31:25];
    assign unused_instr = ^cvxif.issue_instr_i[24:15];

    assign dec_ok = is_mac_instr(opcode, funct3, funct7);
    assign accept = cvxif.issue_valid_i && dec_ok;
    assign full   = (count_q == CNT_W'(PEND_DEPTH));
    assign empty  = (count_q == '0);

    assign head     = fifo_q[rd_ptr_q];
    assign head_id  = head.id;
    assign needs_wb = (head.op != ACCWR);
    // Result slot is usable if empty or being drained on this same edge.
    assign res_free   = !res_valid_q || cvxif.result_ready_i;
    assign head_match = cvxif.commit_valid_i && !empty && (head_id == cvxif.commit_id_i);
    assign pop        = head_match && (cvxif.commit_kill_i || !needs_wb || res_free);
    assign exec       = pop && !cvxif.commit_kill_i;
    assign load_res   = exec && needs_wb;

    assign cvxif.issue_accept_o    = accept;
    assign cvxif.issue_writeback_o = accept && (funct3 != 3'd3);
    assign cvxif.issue_ready_o     = cvxif.issue_valid_i &&
        (!dec_ok || ((cvxif.issue_rs_valid_i == 2'b11) && (!full || pop)));
    assign push = accept && cvxif.issue_ready_o;

    assign new_entry = '{id:  cvxif.issue_id_i,
                         rd:  cvxif.issue_instr_i[11:7],
                         op:  mac_op_e'(funct3),
                         rs1: cvxif.issue_rs_i[XLEN-1:0],
                         rs2: cvxif.issue_rs_i[2*XLEN-1:XLEN]};

    cvxif_mac_dotp4 u_dotp (
        .a (head.rs1),
        .b (head.rs2),
        .y (dotp)
    );

    assign mac_wrap = acc_q + dotp;

`ifdef CVXIF_MAC_SATURATE_EN
    logic mac_ovf;
    assign mac_ovf = (acc_q[XLEN-1] == dotp[XLEN-1]) && (mac_wrap[XLEN-1] != acc_q[XLEN-1]);
    assign mac_sum = !mac_ovf       ? mac_wrap :
                     acc_q[XLEN-1]  ? {1'b1, {(XLEN-1){1'b0}}} :
                                      {1'b0, {(XLEN-1){1'b1}}};
`else
    assign mac_sum = mac_wrap;
`endif

    always_comb begin
        acc_d    = acc_q;
        res_data = dotp;
        case (head.op)
            MAC: begin
                res_data = mac_sum;
                if (exec) acc_d = mac_sum;
            end
            ACCRD: begin
                res_data = acc_q;
                if (exec) acc_d = '0;
            end
            ACCWR: begin
                if (exec) acc_d = head.rs1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
            acc_q <= acc_d;
            if (load_res) begin
                res_valid_q <= 1'b1;
                res_q       <= '{id: head.id, rd: head.rd, data: res_data};
            end else if (cvxif.result_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign cvxif.result_valid_o = res_valid_q;
    assign cvxif.result_we_o    = res_valid_q;
    assign cvxif.result_id_o    = res_q.id;
    assign cvxif.result_rd_o    = res_q.rd;
    assign cvxif.result_data_o  = res_q.data;

endmodule

// File: doc/cvxif_mac_coproc.md
Name: cvxif_mac_coproc

Overview:
- CV-X-IF responder (coprocessor side) for the CVA6 core, which acts as the X-interface initiator.
- Accelerates MNIST inference kernels: signed int8x4 dot product, plus an internal 32-bit accumulator with MAC, read-and-clear and write operations.
- Sits beside the core on the CVXIF port. Only instructions in the CUSTOM_0 opcode space are accepted.
- Results return through the result channel only after the core commits the instruction. Killed instructions are discarded.

Parameters:
- XLEN, 32, operand and result width.
- ID_WIDTH, 2, transaction id width; matches a 4-entry scoreboard.
- PEND_DEPTH, 2, depth of the pending-instruction FIFO that holds instructions awaiting commit (power of two).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  transaction id
- issue_rs_i  in  2*XLEN  {rs2, rs1}
- issue_rs_valid_i  in  2  per-operand valid
- issue_accept_o  out  1  instruction belongs to this coprocessor
- issue_writeback_o  out  1  instruction will write rd
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  ID_WIDTH  id being committed
- commit_kill_i  in  1  discard the instruction instead of executing it
- result_valid_o  out  1  result valid
- result_ready_i  in  1  result accepted by core
- result_id_o  out  ID_WIDTH  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): FIFO empty, accumulator cleared, result register empty. All outputs read 0.
- Decode (combinational): opcode == 7'b0001011 selects this coprocessor. funct7 must be 0. funct3 selects the operation:
  - 0 DOTP4: rd = sum of rs1.b[i]*rs2.b[i], signed, i=0..3.
  - 1 MAC: acc += DOTP4; rd = new acc.
  - 2 ACCRD: rd = acc; acc = 0.
  - 3 ACCWR: acc = rs1; no writeback.
  - Any other funct3, funct7 or opcode is not accepted.
- issue_accept_o and issue_writeback_o are combinational from the decode. writeback = accept && funct3 != 3.
- Handshake rules:
  - An unaccepted instruction completes its handshake immediately: issue_ready_o=1 and accept=0.
  - An accepted instruction waits for issue_ready_o, which is 1 only when issue_rs_valid_i==2'b11 and the FIFO is not full.
  - On issue_valid_i && issue_ready_o && accept, push {id, rd, funct3, rs1, rs2} into the FIFO.
- Commit:
  - Commits arrive in issue order. A commit_valid_i whose id matches the FIFO head pops the head.
  - Non-matching ids and commits while the FIFO is empty are ignored.
  - On a pop with kill=1: no accumulator change, no result.
  - On a pop with kill=0: the operation executes in that cycle. Accumulator updates take effect at the next edge.
  - For funct3 != 3, the result register is loaded at the next edge. Commit-to-result_valid latency is 1 cycle.
- Result register:
  - Single entry. It holds its value stably while result_valid_o && !result_ready_i.
  - A non-killed head that needs writeback is not popped while the result register is full and not draining in the same cycle. That commit is held off: the commit strobe is treated as not taken, and the core is required to re-present it.
  - ACCWR and kills pop regardless of result register state.
- result_we_o equals result_valid_o. result_rd_o comes from instr[11:7].
- Simultaneous push and pop on a full FIFO is permitted (ready accounts for the pop).
- Pointers wrap modulo PEND_DEPTH.
- Accumulator arithmetic: 32-bit two's complement. DOTP4 products are 16-bit signed; the sum is sign-extended to 32 bits.

Optional Feature:
- Macro CVXIF_MAC_SATURATE_EN.
- Defined: the MAC add saturates to 0x7FFFFFFF / 0x80000000 on signed overflow.
- Undefined: the MAC add wraps modulo 2^32.
- DOTP4 never overflows, so it is unaffected.

Decomposition:
- Package cvxif_mac_pkg holds:
  - OPCODE_CUSTOM0 constant.
  - funct3 enum mac_op_e {DOTP4, MAC, ACCRD, ACCWR}.
  - pend_entry_t struct {id, rd, op, rs1, rs2}.
  - result_t struct.
- One sub-module: cvxif_mac_dotp4, a combinational 4-lane signed int8 dot product producing 32 bits.

Test Plan:
- DOTP4, rs1=0x01020304, rs2=0x01010101, id=1, commit no-kill → result 1 cycle later: data=0x0000000A, id=1, we=1.
- DOTP4, rs1=0xFFFFFFFF, rs2=0x02020202 → data=0xFFFFFFF8. Same sequence with commit_kill_i=1 → no result_valid_o, FIFO empty.
- ACCWR rs1=0, then MAC rs1=rs2=0x7F7F7F7F → data=0x0000FC04. Then ACCRD → 0x0000FC04. Then ACCRD again → 0.
- ACCWR rs1=0x7FFFFF00, then MAC rs1=rs2=0x7F7F7F7F → 0x8000FB04 without macro, 0x7FFFFFFF with CVXIF_MAC_SATURATE_EN.
- Issue 2 DOTP4 with no commit → third accepted issue sees issue_ready_o=0. Opcode 0x33 still gets ready=1, accept=0. Hold result_ready_i=0 → result data stable and second commit held off until drain.
- Assert rst_ni=0 with the FIFO holding 2 entries and the result pending → next cycle all outputs 0; a later commit of the old ids produces no result.
